ahb_sfr_bridge: RTL and testbench
=================================

# ahb_sfr_bridge

AHB-Lite slave to APB2 master bridge sitting directly upstream of the SoC special-function-register block. It converts single-word AHB transfers into two-phase APB SETUP/ACCESS cycles on the `apb_sfr_*` bus and returns read data and status to AHB. It rejects illegal transfers (bad size, unaligned, out-of-range word index) without touching the APB side. The APB side has no PREADY/PSLVERR, so every APB access is exactly two cycles.

## Interface
- `SFR_WORDS`, default 8: number of implemented 32-bit registers. Legal word index is `haddr[7:2] < SFR_WORDS`.
- `sys_clk` input 1: single clock for AHB and APB sides.
- `rst_b` input 1: asynchronous, active-low reset.
- `hsel` input 1: AHB slave select.
- `haddr` input 32: AHB address.
- `htrans` input 2: AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- `hwrite` input 1: 1 = write.
- `hsize` input 3: transfer size; only 3'b010 (word) is legal.
- `hwdata` input 32: write data, valid in the data phase.
- `hready` input 1: bus-level HREADY.
- `hreadyout` output 1: slave ready.
- `hresp` output 1: 0 OKAY, 1 ERROR.
- `hrdata` output 32: read data, registered.
- `apb_sfr_paddr` output 32, `apb_sfr_psel` output 1, `apb_sfr_penable` output 1, `apb_sfr_pwrite` output 1, `apb_sfr_pwdata` output 32: APB master outputs, all registered.
- `sfr_apb_prdata` input 32: APB read data. It is only valid while psel, penable and !pwrite are all high.

## Operation
- Accept condition: `hsel & htrans[1] & hready`. IDLE and BUSY transfers get a zero-wait OKAY response and have no effect.
- Legal transfer: `hsize==3'b010`, `haddr[1:0]==0`, and `haddr[7:2] < SFR_WORDS`.
- On accept, latch haddr and hwrite. Move to LATCH for a legal transfer, or to ERR1 for an illegal one (see Configuration).
- FSM states: IDLE, LATCH, SETUP, ACCESS, DONE, ERR1, ERR2.
  - IDLE → LATCH or ERR1 on accept.
  - LATCH: capture hwdata into pwdata (writes only), then → SETUP.
  - SETUP: psel=1, penable=0, then → ACCESS.
  - ACCESS: psel=1, penable=1. At the end of ACCESS, capture sfr_apb_prdata into hrdata (reads only), then → DONE.
  - DONE: hreadyout=1. A new accept in DONE → LATCH or ERR1 (back-to-back). Otherwise → IDLE.
  - ERR1: hreadyout=0, hresp=1, then → ERR2.
  - ERR2: hreadyout=1, hresp=1. Accept here is handled as in DONE.
- hreadyout is 0 in LATCH, SETUP, ACCESS and ERR1, and 1 elsewhere. hresp is 1 only in ERR1 and ERR2.
- paddr and pwrite are loaded at accept and held stable through ACCESS. pwdata holds its last value after the transfer.
- hrdata is updated only by completed reads. Writes and errors leave it unchanged.
- Reset values: hreadyout=1, hresp=0, hrdata=0, paddr=0, psel=0, penable=0, pwrite=0, pwdata=0, FSM=IDLE.
- Reset asserted mid-transfer aborts it immediately. psel and penable drop asynchronously. No partial write is guaranteed beyond an already-completed ACCESS edge.

## Timing
- Accept edge T0. LATCH is T0–T1, SETUP T1–T2, ACCESS T2–T3. The SFR register updates at T3. DONE is T3–T4 with hreadyout=1.
- Data phase is 4 cycles (3 wait states) for both read and write. hrdata is valid during DONE.
- Back-to-back: for a new transfer accepted at the end of DONE, its SETUP follows 2 cycles later. At most one APB access is in flight at any time.
- Error: 2-cycle response (ERR1, ERR2). psel never rises.

## Configuration
- `AHB_SFR_BRIDGE_ERR_RESP_EN` defined: illegal transfers take the ERR1/ERR2 path and return hresp=1.
- `AHB_SFR_BRIDGE_ERR_RESP_EN` undefined: illegal transfers take a single DONE cycle with hresp=0 and produce no APB access. Reads return hrdata unchanged and writes are dropped. The ERR states are not synthesised.

## Test plan
- Reset, then write 0xDEADBEEF to haddr 0x08:
  - APB shows SETUP with paddr=0x08, pwrite=1, pwdata=0xDEADBEEF, then ACCESS.
  - hreadyout is low for 3 cycles. sfr_reg_02=0xDEADBEEF.
- Read haddr 0x1C after reset: hrdata=0x00070007 in DONE, 4-cycle data phase, hresp=0.
- Back-to-back write 0x04 then read 0x04 with hwdata=0x12345678: the read returns 0x12345678, and exactly two APB SETUP/ACCESS pairs occur.
- Write haddr 0x20 (index 8), hsize=halfword, and haddr 0x02 (each with the macro defined):
  - Each gives a 2-cycle ERROR with psel never asserted; registers are unchanged.
  - Repeat with the macro undefined: OKAY, no APB access.
- Assert rst_b low during SETUP of a write: psel and penable go to 0 asynchronously, hreadyout=1, and the target register keeps its prior value.
- BUSY and IDLE htrans with hsel=1: hreadyout stays 1, hresp=0, no APB activity.

Source files
------------

// File: rtl/ahb_sfr_bridge.sv
// AHB-Lite slave to APB2 master bridge feeding the SFR block; each legal word transfer becomes one SETUP/ACCESS pair.
// Define AHB_SFR_BRIDGE_ERR_RESP_EN to answer illegal transfers with a two-cycle ERROR instead of a silent OKAY.
module ahb_sfr_bridge #(
   parameter int SFR_WORDS = 8
) (
   input  logic        sys_clk,
   input  logic        rst_b,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata,
   output logic [31:0] apb_sfr_paddr,
   output logic        apb_sfr_psel,
   output logic        apb_sfr_penable,
   output logic        apb_sfr_pwrite,
   output logic [31:0] apb_sfr_pwdata,
   input  logic [31:0] sfr_apb_prdata
);

   localparam logic [31:0] WORD_LIMIT = 32'(SFR_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE
`ifdef AHB_SFR_BRIDGE_ERR_RESP_EN
      ,
      ST_ERR1,
      ST_ERR2
`endif
   } state_t;

   state_t state;
   logic   accept;
   logic   legal;
   logic   can_start;

   assign accept    = hsel & htrans[1] & hready;
   assign legal     = (hsize == 3'b010) && (haddr[1:0] == 2'b00) &&
                      ({26'd0, haddr[7:2]} < WORD_LIMIT);
`ifdef AHB_SFR_BRIDGE_ERR_RESP_EN
   assign can_start = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
`else
   assign can_start = (state == ST_IDLE) || (state == ST_DONE);
`endif

   // New address phases are only taken while the data phase is completing, so one APB access at most is in flight.
   always_ff @(posedge sys_clk or negedge rst_b) begin
      if (!rst_b) begin
         state           <= ST_IDLE;
         hreadyout       <= 1'b1;
         hresp           <= 1'b0;
         hrdata          <= 32'd0;
         apb_sfr_paddr   <= 32'd0;
         apb_sfr_psel    <= 1'b0;
         apb_sfr_penable <= 1'b0;
         apb_sfr_pwrite  <= 1'b0;
         apb_sfr_pwdata  <= 32'd0;
      end else if (accept && can_start) begin
         apb_sfr_paddr  <= haddr;
         apb_sfr_pwrite <= hwrite;
         if (legal) begin
            state     <= ST_LATCH;
            hreadyout <= 1'b0;
            hresp     <= 1'b0;
         end else begin
`ifdef AHB_SFR_BRIDGE_ERR_RESP_EN
            state     <= ST_ERR1;
            hreadyout <= 1'b0;
            hresp     <= 1'b1;
`else
            state     <= ST_DONE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
`endif
         end
      end else begin
         case (state)
            ST_LATCH: begin
               if (apb_sfr_pwrite) begin
                  apb_sfr_pwdata <= hwdata;
               end
               apb_sfr_psel <= 1'b1;
               state        <= ST_SETUP;
            end
            ST_SETUP: begin
               apb_sfr_penable <= 1'b1;
               state           <= ST_ACCESS;
            end
            // prdata is only trustworthy in ACCESS of a read, so this is the single place hrdata moves.
            ST_ACCESS: begin
               if (!apb_sfr_pwrite) begin
                  hrdata <= sfr_apb_prdata;
               end
               apb_sfr_psel    <= 1'b0;
               apb_sfr_penable <= 1'b0;
               hreadyout       <= 1'b1;
               state           <= ST_DONE;
            end
`ifdef AHB_SFR_BRIDGE_ERR_RESP_EN
            ST_ERR1: begin
               hreadyout <= 1'b1;
               state     <= ST_ERR2;
            end
`endif
            default: begin
               hreadyout <= 1'b1;
               hresp     <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_sfr_bridge.sv
// Randomised self-checking bench for ahb_sfr_bridge with an SFR stub on the APB side and a transfer-level reference model.
module tb_ahb_sfr_bridge;

`ifdef AHB_SFR_BRIDGE_ERR_RESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int SFR_WORDS = 8;

   logic        sys_clk = 1'b0;
   logic        rst_b;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;
   logic [31:0] apb_sfr_paddr;
   logic        apb_sfr_psel;
   logic        apb_sfr_penable;
   logic        apb_sfr_pwrite;
   logic [31:0] apb_sfr_pwdata;
   logic [31:0] sfr_apb_prdata;

   int errors = 0;
   int checks = 0;

   logic [31:0] sfr_regs [0:63];
   logic [31:0] prdata_noise;
   int          setup_cnt = 0;
   int          access_cnt = 0;
   int          psel_cnt = 0;

   logic [31:0] exp_regs [0:SFR_WORDS-1];
   logic [31:0] exp_hrdata;

   int          x_waits;
   logic        x_resp;
   logic [31:0] x_rdata;
   logic        x_timeout;
   logic        x_setup_seen;
   logic [31:0] x_paddr;
   logic        x_pwrite;
   logic [31:0] x_pwdata;

   always #5 sys_clk = ~sys_clk;

   // Single-slave system: the bus HREADY is this slave's HREADYOUT.
   assign hready = hreadyout;

   ahb_sfr_bridge #(.SFR_WORDS(SFR_WORDS)) dut (
      .sys_clk(sys_clk),
      .rst_b(rst_b),
      .hsel(hsel),
      .haddr(haddr),
      .htrans(htrans),
      .hwrite(hwrite),
      .hsize(hsize),
      .hwdata(hwdata),
      .hready(hready),
      .hreadyout(hreadyout),
      .hresp(hresp),
      .hrdata(hrdata),
      .apb_sfr_paddr(apb_sfr_paddr),
      .apb_sfr_psel(apb_sfr_psel),
      .apb_sfr_penable(apb_sfr_penable),
      .apb_sfr_pwrite(apb_sfr_pwrite),
      .apb_sfr_pwdata(apb_sfr_pwdata),
      .sfr_apb_prdata(sfr_apb_prdata)
   );

   // SFR stub: read data is garbage outside a read ACCESS so mistimed captures show up.
   assign sfr_apb_prdata = (apb_sfr_psel && apb_sfr_penable && !apb_sfr_pwrite) ?
                           sfr_regs[apb_sfr_paddr[7:2]] : prdata_noise;

   always @(posedge sys_clk) begin
      prdata_noise <= $urandom;
      if (apb_sfr_psel) psel_cnt <= psel_cnt + 1;
      if (apb_sfr_psel && !apb_sfr_penable) setup_cnt <= setup_cnt + 1;
      if (apb_sfr_psel && apb_sfr_penable) begin
         access_cnt <= access_cnt + 1;
         if (apb_sfr_pwrite) sfr_regs[apb_sfr_paddr[7:2]] <= apb_sfr_pwdata;
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) sfr_regs[i] = {16'(i), 16'(i)};
      for (int i = 0; i < SFR_WORDS; i++) exp_regs[i] = {16'(i), 16'(i)};
      exp_hrdata = 32'd0;
   end

   // One complete AHB transfer; called and returning on a falling edge.
   task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdata);
      hsel   = 1'b1;
      haddr  = addr;
      htrans = 2'b10;
      hwrite = wr;
      hsize  = size;
      @(posedge sys_clk);
      #1;
      hsel   = 1'b0;
      htrans = 2'b00;
      hwdata = wr ? wdata : $urandom;
      x_waits = 0;
      x_timeout = 1'b1;
      x_setup_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         x_waits++;
         if (apb_sfr_psel && !apb_sfr_penable && !x_setup_seen) begin
            x_setup_seen = 1'b1;
            x_paddr  = apb_sfr_paddr;
            x_pwrite = apb_sfr_pwrite;
            x_pwdata = apb_sfr_pwdata;
         end
         if (hreadyout) begin
            x_timeout = 1'b0;
            x_resp  = hresp;
            x_rdata = hrdata;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_b = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = '0;
      repeat (3) @(negedge sys_clk);
      checks++; if (hreadyout !== 1'b1) begin errors++; $display("[TB] FAIL reset_hreadyout got %b want 1", hreadyout); end
      checks++; if (hresp !== 1'b0) begin errors++; $display("[TB] FAIL reset_hresp got %b want 0", hresp); end
      checks++; if (hrdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_hrdata got %h want 0", hrdata); end
      checks++; if (apb_sfr_paddr !== 32'd0) begin errors++; $display("[TB] FAIL reset_paddr got %h want 0", apb_sfr_paddr); end
      checks++; if (apb_sfr_psel !== 1'b0 || apb_sfr_penable !== 1'b0) begin errors++; $display("[TB] FAIL reset_psel_penable got %b%b want 00", apb_sfr_psel, apb_sfr_penable); end
      checks++; if (apb_sfr_pwrite !== 1'b0 || apb_sfr_pwdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_pwrite_pwdata got %b/%h want 0/0", apb_sfr_pwrite, apb_sfr_pwdata); end
      rst_b = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic test_read_reset_value;
      do_xfer(32'h1C, 1'b0, 3'b010, 32'd0);
      exp_hrdata = exp_regs[7];
      checks++; if (x_timeout !== 1'b0) begin errors++; $display("[TB] FAIL read1c_timeout got %b want 0", x_timeout); end
      checks++; if (x_rdata !== 32'h00070007) begin errors++; $display("[TB] FAIL read1c_data got %h want 00070007", x_rdata); end
      checks++; if (x_waits !== 4) begin errors++; $display("[TB] FAIL read1c_cycles got %0d want 4", x_waits); end
      checks++; if (x_resp !== 1'b0) begin errors++; $display("[TB] FAIL read1c_hresp got %b want 0", x_resp); end
   endtask

   task automatic test_write;
      int s0, a0;
      s0 = setup_cnt; a0 = access_cnt;
      do_xfer(32'h08, 1'b1, 3'b010, 32'hDEADBEEF);
      exp_regs[2] = 32'hDEADBEEF;
      checks++; if (x_setup_seen !== 1'b1) begin errors++; $display("[TB] FAIL wr08_setup_seen got %b want 1", x_setup_seen); end
      checks++; if (x_paddr !== 32'h08 || x_pwrite !== 1'b1) begin errors++; $display("[TB] FAIL wr08_paddr_pwrite got %h/%b want 00000008/1", x_paddr, x_pwrite); end
      checks++; if (x_pwdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr08_pwdata got %h want deadbeef", x_pwdata); end
      checks++; if (x_waits - 1 !== 3) begin errors++; $display("[TB] FAIL wr08_wait_states got %0d want 3", x_waits - 1); end
      checks++; if (x_resp !== 1'b0) begin errors++; $display("[TB] FAIL wr08_hresp got %b want 0", x_resp); end
      checks++; if (setup_cnt - s0 !== 1 || access_cnt - a0 !== 1) begin errors++; $display("[TB] FAIL wr08_apb_pairs got %0d/%0d want 1/1", setup_cnt - s0, access_cnt - a0); end
      checks++; if (sfr_regs[2] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr08_sfr_reg_02 got %h want deadbeef", sfr_regs[2]); end
      checks++; if (x_rdata !== exp_hrdata) begin errors++; $display("[TB] FAIL wr08_hrdata_kept got %h want %h", x_rdata, exp_hrdata); end
   endtask

   task automatic test_back_to_back;
      int s0, a0, w_waits;
      s0 = setup_cnt; a0 = access_cnt;
      do_xfer(32'h04, 1'b1, 3'b010, 32'h12345678);
      w_waits = x_waits;
      exp_regs[1] = 32'h12345678;
      do_xfer(32'h04, 1'b0, 3'b010, 32'd0);
      exp_hrdata = exp_regs[1];
      checks++; if (x_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL b2b_read_data got %h want 12345678", x_rdata); end
      checks++; if (w_waits !== 4 || x_waits !== 4) begin errors++; $display("[TB] FAIL b2b_cycles got %0d/%0d want 4/4", w_waits, x_waits); end
      checks++; if (setup_cnt - s0 !== 2 || access_cnt - a0 !== 2) begin errors++; $display("[TB] FAIL b2b_apb_pairs got %0d/%0d want 2/2", setup_cnt - s0, access_cnt - a0); end
   endtask

   task automatic test_illegal;
      logic [31:0] addrs [3];
      logic [2:0]  sizes [3];
      int p0;
      addrs[0] = 32'h20; sizes[0] = 3'b010;
      addrs[1] = 32'h08; sizes[1] = 3'b001;
      addrs[2] = 32'h02; sizes[2] = 3'b010;
      for (int k = 0; k < 3; k++) begin
         p0 = psel_cnt;
         do_xfer(addrs[k], 1'b1, sizes[k], $urandom);
         checks++; if (x_resp !== ERR_EN) begin errors++; $display("[TB] FAIL illegal%0d_hresp got %b want %b", k, x_resp, ERR_EN); end
         checks++; if (x_waits !== (ERR_EN ? 2 : 1)) begin errors++; $display("[TB] FAIL illegal%0d_cycles got %0d want %0d", k, x_waits, ERR_EN ? 2 : 1); end
         checks++; if (psel_cnt !== p0 || x_setup_seen !== 1'b0) begin errors++; $display("[TB] FAIL illegal%0d_psel got %0d cycles want 0", k, psel_cnt - p0); end
      end
      for (int i = 0; i < SFR_WORDS; i++) begin
         checks++; if (sfr_regs[i] !== exp_regs[i]) begin errors++; $display("[TB] FAIL illegal_reg%0d got %h want %h", i, sfr_regs[i], exp_regs[i]); end
      end
   endtask

   task automatic test_idle_busy;
      int s0;
      s0 = setup_cnt;
      hsel = 1'b1; haddr = 32'h08; hwrite = 1'b1; hsize = 3'b010;
      for (int t = 0; t < 2; t++) begin
         htrans = (t == 0) ? 2'b00 : 2'b01;
         for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || apb_sfr_psel !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy_%0d got rdy=%b resp=%b psel=%b want 1/0/0", t, hreadyout, hresp, apb_sfr_psel); end
         end
      end
      hsel = 1'b0; htrans = 2'b00;
      @(negedge sys_clk);
      checks++; if (setup_cnt !== s0) begin errors++; $display("[TB] FAIL idle_busy_apb got %0d setups want 0", setup_cnt - s0); end
   endtask

   task automatic test_reset_mid;
      logic found;
      found = 1'b0;
      hsel = 1'b1; haddr = 32'h14; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
      @(posedge sys_clk);
      #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = 32'hA5A55A5A;
      for (int i = 0; i < 10; i++) begin
         @(negedge sys_clk);
         if (apb_sfr_psel && !apb_sfr_penable) begin found = 1'b1; break; end
      end
      checks++; if (found !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_setup_reached got %b want 1", found); end
      #2 rst_b = 1'b0;
      #1;
      checks++; if (apb_sfr_psel !== 1'b0 || apb_sfr_penable !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_async_drop got %b%b want 00", apb_sfr_psel, apb_sfr_penable); end
      checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_hready got %b/%b want 1/0", hreadyout, hresp); end
      @(negedge sys_clk);
      rst_b = 1'b1;
      exp_hrdata = 32'd0;
      @(negedge sys_clk);
      checks++; if (sfr_regs[5] !== exp_regs[5]) begin errors++; $display("[TB] FAIL rstmid_reg05 got %h want %h", sfr_regs[5], exp_regs[5]); end
      checks++; if (hrdata !== exp_hrdata) begin errors++; $display("[TB] FAIL rstmid_hrdata got %h want %h", hrdata, exp_hrdata); end
   endtask

   // Reference model works on whole transfers: legality, register array and last read value.
   task automatic test_random;
      logic [31:0] addr, wdata;
      logic [2:0]  size;
      logic        wr, legal;
      int          sel, gap, s0, idx;
      for (int n = 0; n < 60; n++) begin
         sel = $urandom_range(0, 9);
         addr = {$urandom} & 32'hFFFF_FF00;
         if (sel < 8) addr[7:0] = 8'(sel * 4);
         else if (sel == 8) addr[7:0] = 8'(32 + 4 * $urandom_range(0, 7));
         else addr[7:0] = 8'(4 * $urandom_range(0, 7) + $urandom_range(1, 3));
         size = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
         wr = 1'($urandom);
         wdata = $urandom;
         idx = int'(addr[7:2]);
         legal = (size == 3'b010) && (addr % 4 == 0) && (idx < SFR_WORDS);
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge sys_clk);
         s0 = setup_cnt;
         do_xfer(addr, wr, size, wdata);
         if (legal && wr) exp_regs[idx] = wdata;
         if (legal && !wr) exp_hrdata = exp_regs[idx];
         checks++; if (x_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_timeout addr=%h", n, addr); end
         checks++; if (x_rdata !== exp_hrdata) begin errors++; $display("[TB] FAIL rnd%0d_hrdata addr=%h wr=%b got %h want %h", n, addr, wr, x_rdata, exp_hrdata); end
         checks++; if (x_resp !== (!legal && ERR_EN)) begin errors++; $display("[TB] FAIL rnd%0d_hresp addr=%h got %b want %b", n, addr, x_resp, !legal && ERR_EN); end
         checks++; if (x_waits !== (legal ? 4 : (ERR_EN ? 2 : 1))) begin errors++; $display("[TB] FAIL rnd%0d_cycles addr=%h got %0d want %0d", n, addr, x_waits, legal ? 4 : (ERR_EN ? 2 : 1)); end
         checks++; if (setup_cnt - s0 !== (legal ? 1 : 0)) begin errors++; $display("[TB] FAIL rnd%0d_apb_count addr=%h got %0d want %0d", n, addr, setup_cnt - s0, legal ? 1 : 0); end
      end
      @(negedge sys_clk);
      for (int i = 0; i < SFR_WORDS; i++) begin
         checks++; if (sfr_regs[i] !== exp_regs[i]) begin errors++; $display("[TB] FAIL rnd_final_reg%0d got %h want %h", i, sfr_regs[i], exp_regs[i]); end
      end
   endtask

   initial begin
      test_reset;
      test_read_reset_value;
      test_write;
      test_back_to_back;
      test_illegal;
      test_idle_busy;
      test_reset_mid;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired before the bench completed");
      $fatal(1, "[TB] watchdog");
   end

endmodule
